// File: rtl/hsid_band_streamer.sv
// hsid_band_streamer: streams pixel/library band packs per reference into the MSE unit,
// throttled at reference boundaries by sink_ready.
module hsid_band_streamer #(
    parameter int WORD_WIDTH        = 32,
    parameter int HSP_BANDS_WIDTH   = 9,
    parameter int HSP_LIBRARY_WIDTH = 8,
    parameter int ADDR_WIDTH        = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         start,
    input  logic [HSP_BANDS_WIDTH-1:0]   hsp_bands,
    input  logic [HSP_LIBRARY_WIDTH-1:0] library_size,
    input  logic                         sink_ready,
    output logic                         pixel_rd_en,
    output logic [HSP_BANDS_WIDTH-2:0]   pixel_rd_addr,
    input  logic [WORD_WIDTH-1:0]        pixel_rd_data,
    output logic                         lib_rd_en,
    output logic [ADDR_WIDTH-1:0]        lib_rd_addr,
    input  logic [WORD_WIDTH-1:0]        lib_rd_data,
    output logic [WORD_WIDTH-1:0]        band_pack_a,
    output logic [WORD_WIDTH-1:0]        band_pack_b,
    output logic                         band_pack_valid,
    output logic                         band_pack_start,
    output logic                         band_pack_last,
    output logic [HSP_LIBRARY_WIDTH-1:0] hsp_ref,
    output logic [HSP_BANDS_WIDTH-1:0]   hsp_bands_out,
    output logic                         busy,
    output logic                         done
);
    localparam int HALF = WORD_WIDTH / 2;
    localparam int PW   = HSP_BANDS_WIDTH - 1;

    typedef enum logic [2:0] {IDLE, WAIT_SINK, READ, FLUSH, DONE} state_t;

    state_t                       state, state_nx;
    logic [HSP_BANDS_WIDTH-1:0]   bands_q, words_q, words_in;
    logic [HSP_LIBRARY_WIDTH-1:0] lib_size_q, r, r_nx, s1_ref;
    logic [PW-1:0]                w, w_nx;
    logic [ADDR_WIDTH-1:0]        base, base_nx;
    logic                         rd_en, word_last, ref_last, pad;
    logic                         s1_valid, s1_first, s1_last;
    logic [WORD_WIDTH-1:0]        keep;

    assign words_in      = (hsp_bands >> 1) + HSP_BANDS_WIDTH'(hsp_bands[0]);
    assign word_last     = {1'b0, w} == words_q - 1'b1;
    assign ref_last      = r == lib_size_q - 1'b1;
    assign rd_en         = state == READ;
    assign pixel_rd_en   = rd_en;
    assign lib_rd_en     = rd_en;
    assign pixel_rd_addr = w;
    assign lib_rd_addr   = base + ADDR_WIDTH'(w);
    assign busy          = state == WAIT_SINK || state == READ || state == FLUSH;
    assign done          = state == DONE;
    // odd band count: the padding band in the upper half must contribute zero difference
    assign pad           = s1_last && bands_q[0];
    assign keep          = {{HALF{~pad}}, {HALF{1'b1}}};

    always_comb begin
        state_nx = state;
        w_nx     = w;
        r_nx     = r;
        base_nx  = base;
        case (state)
            IDLE:      if (start) state_nx = (hsp_bands == '0 || library_size == '0) ? DONE : WAIT_SINK;
            WAIT_SINK: if (sink_ready) state_nx = READ;
            READ: begin
                w_nx = word_last ? '0 : w + 1'b1;
                if (word_last) begin
                    state_nx = ref_last ? FLUSH : WAIT_SINK;
                    r_nx     = ref_last ? r : r + 1'b1;
                    base_nx  = ref_last ? base : base + ADDR_WIDTH'(words_q);
                end
            end
            FLUSH: begin
                w_nx     = w[0] ? '0 : w + 1'b1;
                state_nx = w[0] ? DONE : FLUSH;
            end
            DONE: begin
                state_nx = IDLE;
                r_nx     = '0;
                base_nx  = '0;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            w               <= '0;
            r               <= '0;
            base            <= '0;
            bands_q         <= '0;
            lib_size_q      <= '0;
            words_q         <= '0;
            s1_valid        <= 1'b0;
            s1_first        <= 1'b0;
            s1_last         <= 1'b0;
            s1_ref          <= '0;
            band_pack_valid <= 1'b0;
            band_pack_start <= 1'b0;
            band_pack_last  <= 1'b0;
            band_pack_a     <= '0;
            band_pack_b     <= '0;
            hsp_ref         <= '0;
            hsp_bands_out   <= '0;
        end else if (clear) begin
            state           <= IDLE;
            w               <= '0;
            r               <= '0;
            base            <= '0;
            bands_q         <= '0;
            lib_size_q      <= '0;
            words_q         <= '0;
            s1_valid        <= 1'b0;
            s1_first        <= 1'b0;
            s1_last         <= 1'b0;
            s1_ref          <= '0;
            band_pack_valid <= 1'b0;
            band_pack_start <= 1'b0;
            band_pack_last  <= 1'b0;
            band_pack_a     <= '0;
            band_pack_b     <= '0;
            hsp_ref         <= '0;
            hsp_bands_out   <= '0;
        end else begin
            state <= state_nx;
            w     <= w_nx;
            r     <= r_nx;
            base  <= base_nx;
            if (state == IDLE && start) begin
                bands_q    <= hsp_bands;
                lib_size_q <= library_size;
                words_q    <= words_in;
            end
            // sideband travels alongside the one-cycle memory latency
            s1_valid        <= rd_en;
            s1_first        <= rd_en && w == '0;
            s1_last         <= rd_en && word_last;
            s1_ref          <= r;
            band_pack_valid <= s1_valid;
            band_pack_start <= s1_first;
            band_pack_last  <= s1_last;
            if (s1_valid) begin
                band_pack_a   <= pixel_rd_data & keep;
                band_pack_b   <= lib_rd_data & keep;
                hsp_ref       <= s1_ref;
                hsp_bands_out <= bands_q;
            end
        end
    end
endmodule

// File: tb/tb_hsid_band_streamer.sv
// tb_hsid_band_streamer: randomized scoreboard bench for hsid_band_streamer.
module tb_hsid_band_streamer;
    localparam int WW = 32, BW = 9, LW = 8, AW = 16;

    logic          clk = 0, rst_n = 0, clear = 0, start = 0, sink_ready = 1;
    logic [BW-1:0] hsp_bands = '0;
    logic [LW-1:0] library_size = '0;
    logic          pixel_rd_en, lib_rd_en, band_pack_valid, band_pack_start, band_pack_last, busy, done;
    logic [BW-2:0] pixel_rd_addr;
    logic [AW-1:0] lib_rd_addr;
    logic [WW-1:0] pixel_rd_data = '0, lib_rd_data = '0, band_pack_a, band_pack_b;
    logic [LW-1:0] hsp_ref;
    logic [BW-1:0] hsp_bands_out;

    logic [WW-1:0] pix_mem [256];
    logic [WW-1:0] lib_mem [1024];

    typedef struct packed {
        logic [WW-1:0] a;
        logic [WW-1:0] b;
        logic          st;
        logic          la;
        logic [LW-1:0] rf;
        logic [BW-1:0] bn;
    } pack_t;

    pack_t q[$];
    pack_t got, e;
    int checks = 0, errors = 0, n_valid = 0, n_rd = 0, first_cyc = -1, last_cyc = -1, cyc = 0;

    hsid_band_streamer dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .start(start),
        .hsp_bands(hsp_bands), .library_size(library_size), .sink_ready(sink_ready),
        .pixel_rd_en(pixel_rd_en), .pixel_rd_addr(pixel_rd_addr), .pixel_rd_data(pixel_rd_data),
        .lib_rd_en(lib_rd_en), .lib_rd_addr(lib_rd_addr), .lib_rd_data(lib_rd_data),
        .band_pack_a(band_pack_a), .band_pack_b(band_pack_b), .band_pack_valid(band_pack_valid),
        .band_pack_start(band_pack_start), .band_pack_last(band_pack_last),
        .hsp_ref(hsp_ref), .hsp_bands_out(hsp_bands_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (pixel_rd_en) pixel_rd_data <= pix_mem[pixel_rd_addr];
        if (lib_rd_en) lib_rd_data <= lib_mem[lib_rd_addr[9:0]];
    end

    // monitor: pops the scoreboard whenever a band pack is presented
    always @(negedge clk) begin
        if (rst_n) begin
            if (lib_rd_en) n_rd++;
            if (band_pack_valid) begin
                got = {band_pack_a, band_pack_b, band_pack_start, band_pack_last, hsp_ref, hsp_bands_out};
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_valid: got %h, required no valid", got);
                end else begin
                    e = q.pop_front();
                    if (got !== e) begin
                        errors++;
                        $display("FAIL band_pack: got %h required %h", got, e);
                    end
                end
                if (n_valid == 0) first_cyc = cyc;
                last_cyc = cyc;
                n_valid++;
            end
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    function automatic logic [127:0] outs();
        return 128'({pixel_rd_en, pixel_rd_addr, lib_rd_en, lib_rd_addr, band_pack_a, band_pack_b,
                     band_pack_valid, band_pack_start, band_pack_last, hsp_ref, hsp_bands_out, busy, done});
    endfunction

    task automatic fill_mem(input bit pattern);
        for (int i = 0; i < 256; i++) pix_mem[i] = $urandom;
        for (int i = 0; i < 1024; i++) lib_mem[i] = pattern ? 32'h00010002 + 32'(i) * 32'h00020002 : $urandom;
    endtask

    // reference model: per reference r, words w of ceil(bands/2), padding band zeroed
    task automatic launch(input int bands, input int lsize, output int sc, output int total);
        int    wc;
        pack_t p;
        wc    = (bands + 1) / 2;
        total = (bands == 0 || lsize == 0) ? 0 : wc * lsize;
        for (int r = 0; r < lsize && total > 0; r++)
            for (int w = 0; w < wc; w++) begin
                p.a  = pix_mem[w];
                p.b  = lib_mem[r * wc + w];
                if (bands % 2 == 1 && w == wc - 1) begin
                    p.a[31:16] = '0;
                    p.b[31:16] = '0;
                end
                p.st = w == 0;
                p.la = w == wc - 1;
                p.rf = LW'(r);
                p.bn = BW'(bands);
                q.push_back(p);
            end
        n_valid   = 0;
        n_rd      = 0;
        first_cyc = -1;
        @(posedge clk); #1;
        hsp_bands    = BW'(bands);
        library_size = LW'(lsize);
        start        = 1;
        sc           = cyc;
        @(posedge clk); #1;
        start = 0;
        check("busy_after_start", busy, total > 0);
    endtask

    task automatic run(input int bands, input int lsize, input int stall_ref, input bit mid_start);
        int sc, total, wc, rise;
        bit seen = 0, stalled = 0, ms = 0, resumed = 0;
        wc = (bands + 1) / 2;
        launch(bands, lsize, sc, total);
        for (int c = 0; c < 500 && !seen; c++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                if (total > 0) begin
                    check("done_after_last_valid", cyc, last_cyc + 1);
                    check("first_valid_cycle", first_cyc, sc + 4);
                end else
                    check("degenerate_done_cycle", cyc, sc + 1);
                check("busy_at_done", busy, 0);
                check("valid_count", n_valid, total);
                check("read_count", n_rd, total);
                check("queue_empty", q.size(), 0);
            end else if (stall_ref >= 0 && !stalled && lib_rd_en && int'(lib_rd_addr) == (stall_ref + 1) * wc - 1) begin
                stalled = 1;
                for (int k = 0; k < 6; k++) begin
                    @(posedge clk); #1;
                    sink_ready = 0;
                    @(negedge clk);
                    check("stall_no_read", lib_rd_en, 0);
                end
                @(posedge clk); #1;
                sink_ready = 1;
                rise       = cyc;
                for (int k = 0; k < 3 && !resumed; k++) begin
                    @(negedge clk);
                    resumed = lib_rd_en;
                end
                check("stall_resume", resumed, 1);
                check("stall_resume_bound", cyc <= rise + 2, 1);
            end else if (mid_start && !ms && n_valid > 0) begin
                ms = 1;
                @(posedge clk); #1;
                start        = 1;
                hsp_bands    = BW'(bands + 2);
                library_size = 8'd9;
                @(posedge clk); #1;
                start = 0;
            end
        end
        check("done_seen", seen, 1);
    endtask

    task automatic clear_test();
        int sc, total;
        bit any_done = 0, any_rd = 0;
        launch(4, 3, sc, total);
        for (int c = 0; c < 50 && n_valid < 2; c++) @(negedge clk);
        check("clear_reached_mid_run", n_valid >= 2, 1);
        @(posedge clk); #1;
        clear = 1;
        @(posedge clk); #1;
        clear = 0;
        q.delete();
        @(negedge clk);
        check("clear_outputs", outs(), 0);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            any_done |= done;
            any_rd   |= lib_rd_en;
        end
        check("clear_no_done", any_done, 0);
        check("clear_no_read", any_rd, 0);
    endtask

    task automatic reset_test();
        int sc, total;
        launch(6, 2, sc, total);
        for (int c = 0; c < 50 && n_valid < 1; c++) @(negedge clk);
        @(negedge clk); #2;
        rst_n = 0;
        #1;
        check("async_reset_outputs", outs(), 0);
        @(posedge clk); #1;
        q.delete();
        @(negedge clk); #3;
        rst_n = 1;
    endtask

    initial begin
        fill_mem(1);
        #1;
        check("reset_outputs", outs(), 0);
        #11;
        rst_n = 1;
        run(4, 2, -1, 0);
        fill_mem(0);
        run(5, 1, -1, 0);
        run(6, 3, 0, 0);
        run(1, 3, -1, 0);
        run(0, 3, -1, 0);
        run(4, 0, -1, 0);
        run(4, 3, -1, 1);
        clear_test();
        run(3, 2, -1, 0);
        reset_test();
        run(2, 2, -1, 0);
        for (int i = 0; i < 6; i++) begin
            fill_mem(0);
            run($urandom_range(1, 12), $urandom_range(1, 4), -1, 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required finish before 500000");
        $fatal(1);
    end
endmodule
